mem_stage: RTL
==============

# mem_stage

MEM-stage load/store unit of the 5-stage RV32I pipeline. It sits directly downstream of the EX/MEM register and upstream of write-back, and it consumes the `forward_data` store-data select from the forwarding unit. It drives a variable-latency data-memory request/response port, aligns byte lanes, and sign- or zero-extends loads. It owns the MEM/WB register and stalls the upstream pipeline while a memory access is outstanding.

## Interface
- `XLEN`, default 32: datapath width. Only 32 is supported.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `me_valid` in 1: an instruction occupies MEM.
- `me_mem_read`, `me_mem_write` in 1 each: load / store.
- `me_func3` in 3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `me_alu_result` in 32: effective address, or the ALU result for non-memory ops.
- `me_rs2_data` in 32: store data from EX/MEM.
- `me_rd` in 5, `me_regs_write` in 1: destination register and write enable.
- `forward_data` in 1: when 1, store data is taken from `wb_write_data` instead of `me_rs2_data`.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (word aligned), `dmem_wstrb` out 4, `dmem_wdata` out 32: request channel.
- `dmem_ready` in 1: request accepted this cycle.
- `dmem_rvalid` in 1, `dmem_rdata` in 32: load response.
- `mem_stall` out 1: hold IF/ID/EX/EX-MEM this cycle.
- `mem_err` out 1: one-cycle pulse for a misaligned access or illegal func3.
- `wb_valid`, `wb_regs_write` out 1; `wb_rd` out 5; `wb_write_data` out 32: the MEM/WB register.

## Operation
- FSM states:
  - IDLE: new instruction.
  - REQ: request pending, not yet accepted.
  - WAIT: load accepted, awaiting `rvalid`.
- IDLE, memory op (`me_valid` and (read or write)), aligned:
  - `dmem_req`=1 combinationally; address, strobes and data are formed from the live inputs.
  - The same values are latched into request registers.
  - Not ready: go to REQ.
  - Ready and store: retire.
  - Ready and load: go to WAIT.
- REQ: `dmem_req`=1 from the latched registers. On `dmem_ready`, a store retires and returns to IDLE; a load goes to WAIT.
- WAIT: `dmem_req`=0. On `dmem_rvalid`, retire and return to IDLE. `rvalid` is ignored in IDLE and REQ.
- `forward_data` is sampled only in the IDLE cycle. The latched store data is used thereafter, because `wb_*` becomes a bubble during a stall.
- Retire means the MEM/WB register loads at the next edge:
  - `wb_valid`=1, `wb_rd`=`me_rd`, `wb_regs_write`=`me_regs_write`.
  - `wb_write_data` = extended load data for a load, otherwise `me_alu_result`.
- Non-memory or `me_valid`=0 in IDLE: retires immediately, with no stall.
- Any cycle that does not retire loads a bubble into MEM/WB (`wb_valid`=0, `wb_regs_write`=0).
- `mem_stall` = memory op present and not retiring this cycle.
- Store lanes, with a = addr[1:0]:
  - SB: strobe 0001<<a, wdata = the low byte replicated ×4.
  - SH: strobe 0011<<a, wdata = the low half replicated ×2.
  - SW: strobe 1111.
- `dmem_we`=1 for stores; `dmem_wstrb`=0 for loads.
- Load extract: shift `rdata` right by 8·a, then sign-extend (LB/LH) or zero-extend (LBU/LHU/LW) from 8/16/32 bits. The byte offset is taken from the latched address.
- Error cases: LH/LHU/SH with addr[0]=1, LW/SW with a≠0, or func3 ∈ {011, 110, 111} for a memory op.
  - No `dmem_req`, no stall.
  - `mem_err` pulses for 1 cycle.
  - The instruction retires with `wb_regs_write` forced to 0.

## Timing
- Reset (async): state IDLE; all `wb_*`=0, `mem_err`=0, request registers 0. Outputs `dmem_req`=0 and `mem_stall`=0 while in reset.
- Reset asserted mid-access abandons the access. A later `rvalid` is ignored because the FSM is in IDLE.
- Store with ready in cycle 0: zero stall cycles; WB updated at the end of cycle 0.
- Load with ready in cycle 0 and rvalid in cycle 1: 1 stall cycle; WB updated at the end of cycle 1.
- Stall length for a load = cycles until accept + cycles until rvalid.
- `mem_stall` and `dmem_req` are combinational from state and inputs. All `wb_*` outputs and `mem_err` are registered.
- `rvalid` in the same cycle as `ready` is not supported; the memory returns load data ≥1 cycle after accept.

## Test plan
- ALU pass-through: `me_valid`=1, rd=5, `regs_write`=1, alu=0x1234 → next edge `wb_write_data`=0x1234, `wb_rd`=5; `mem_stall` never asserted.
- Forwarded SB: WB holds 0xAABBCCDD; SB at 0x102 with `forward_data`=1, ready immediately → `dmem_addr`=0x100, `wstrb`=0100, `wdata`=0xDDDDDDDD, `dmem_we`=1, no stall.
- Slow LB: addr 0x203; ready in cycle 2, rvalid in cycle 3, `rdata`=0x80123456 → `mem_stall` high in cycles 0–2, low in cycle 3; `wb_write_data`=0xFFFFFF80 after cycle 3.
- LHU at 0x002, `rdata`=0xBEEF1234, ready immediately, rvalid next cycle → `wb_write_data`=0x0000BEEF; exactly 1 stall cycle.
- Misaligned LW at 0x006 → `dmem_req` stays 0; `mem_err`=1 for one cycle; `wb_regs_write`=0, `wb_valid`=1.
- Reset in WAIT, then rvalid 2 cycles later → FSM in IDLE, all `wb_*`=0, no retire from the stray rvalid.

Source files
------------

// File: rtl/mem_stage.sv
// MEM-stage load/store unit: byte-lane alignment, load extension, owns MEM/WB register.
// Latency: ALU ops and stores accepted at once retire in one cycle; otherwise stalls until dmem accept (+ rvalid for loads).
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            me_valid,
  input  logic            me_mem_read,
  input  logic            me_mem_write,
  input  logic [2:0]      me_func3,
  input  logic [XLEN-1:0] me_alu_result,
  input  logic [XLEN-1:0] me_rs2_data,
  input  logic [4:0]      me_rd,
  input  logic            me_regs_write,
  input  logic            forward_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic            mem_err,
  output logic            wb_valid,
  output logic            wb_regs_write,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_write_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] req_wdata_q, req_wdata_d;
  logic [3:0]      req_wstrb_q, req_wstrb_d;
  logic            req_we_q, req_we_d;
  logic [2:0]      req_func3_q, req_func3_d;
  logic            wb_valid_q, wb_valid_d;
  logic            wb_regs_write_q, wb_regs_write_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_write_data_q, wb_write_data_d;
  logic            mem_err_q, mem_err_d;

  logic            mem_op, is_store, illegal, misaligned, err, go;
  logic            retire, load_ret, dmem_req_raw;
  logic [XLEN-1:0] st_src, live_wdata, shifted, ld_data;
  logic [3:0]      live_wstrb;

  // Decode of the live EX/MEM inputs; only meaningful in IDLE.
  always_comb begin
    mem_op     = me_valid & (me_mem_read | me_mem_write);
    is_store   = me_mem_write;
    illegal    = me_func3 inside {3'b011, 3'b110, 3'b111};
    misaligned = ((me_func3[1:0] == 2'b01) & me_alu_result[0]) |
                 ((me_func3[1:0] == 2'b10) & (me_alu_result[1:0] != 2'b00));
    err        = mem_op & (illegal | misaligned);
    go         = mem_op & ~err;
    st_src     = forward_data ? wb_write_data_q : me_rs2_data;
    live_wstrb = 4'b0000;
    live_wdata = st_src;
    if (is_store) begin
      case (me_func3[1:0])
        2'b00: begin
          live_wstrb = 4'b0001 << me_alu_result[1:0];
          live_wdata = {4{st_src[7:0]}};
        end
        2'b01: begin
          live_wstrb = 4'b0011 << me_alu_result[1:0];
          live_wdata = {2{st_src[15:0]}};
        end
        default: live_wstrb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    shifted = dmem_rdata >> {req_addr_q[1:0], 3'b000};
    case (req_func3_q)
      3'b000:  ld_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (!dmem_ready)    state_d = S_REQ;
          else if (!is_store) state_d = S_WAIT;
        end
      end
      S_REQ: begin
        if (dmem_ready) state_d = req_we_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (dmem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_req_raw = 1'b0;
    dmem_we      = req_we_q;
    dmem_addr    = {req_addr_q[XLEN-1:2], 2'b00};
    dmem_wstrb   = req_wstrb_q;
    dmem_wdata   = req_wdata_q;
    retire       = 1'b0;
    load_ret     = 1'b0;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_wstrb_d  = req_wstrb_q;
    req_we_d     = req_we_q;
    req_func3_d  = req_func3_q;
    case (state_q)
      S_IDLE: begin
        dmem_req_raw = go;
        dmem_we      = is_store;
        dmem_addr    = {me_alu_result[XLEN-1:2], 2'b00};
        dmem_wstrb   = live_wstrb;
        dmem_wdata   = live_wdata;
        retire       = ~go | (dmem_ready & is_store);
        if (go) begin
          req_addr_d  = me_alu_result;
          req_wdata_d = live_wdata;
          req_wstrb_d = live_wstrb;
          req_we_d    = is_store;
          req_func3_d = me_func3;
        end
      end
      S_REQ: begin
        dmem_req_raw = 1'b1;
        retire       = dmem_ready & req_we_q;
      end
      S_WAIT: begin
        retire   = dmem_rvalid;
        load_ret = 1'b1;
      end
      default: ;
    endcase

    dmem_req  = dmem_req_raw & ~rst;
    mem_stall = ~retire & ~rst;

    // Bubbles clear the whole MEM/WB register, not just the valid bits.
    wb_valid_d      = retire & ((state_q != S_IDLE) | me_valid);
    wb_regs_write_d = wb_valid_d & me_regs_write & ~((state_q == S_IDLE) & err);
    wb_rd_d         = wb_valid_d ? me_rd : 5'd0;
    wb_write_data_d = wb_valid_d ? (load_ret ? ld_data : me_alu_result) : '0;
    mem_err_d       = (state_q == S_IDLE) & err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr_q      <= '0;
      req_wdata_q     <= '0;
      req_wstrb_q     <= 4'b0000;
      req_we_q        <= 1'b0;
      req_func3_q     <= 3'b000;
      wb_valid_q      <= 1'b0;
      wb_regs_write_q <= 1'b0;
      wb_rd_q         <= 5'd0;
      wb_write_data_q <= '0;
      mem_err_q       <= 1'b0;
    end else begin
      req_addr_q      <= req_addr_d;
      req_wdata_q     <= req_wdata_d;
      req_wstrb_q     <= req_wstrb_d;
      req_we_q        <= req_we_d;
      req_func3_q     <= req_func3_d;
      wb_valid_q      <= wb_valid_d;
      wb_regs_write_q <= wb_regs_write_d;
      wb_rd_q         <= wb_rd_d;
      wb_write_data_q <= wb_write_data_d;
      mem_err_q       <= mem_err_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_regs_write = wb_regs_write_q;
  assign wb_rd         = wb_rd_q;
  assign wb_write_data = wb_write_data_q;
  assign mem_err       = mem_err_q;

endmodule
